// File: rtl/jtopl_wr_seq_if.sv
// Bus bundle for the OPL write sequencer: CPU write port in, register-file replay and globals out.
// Latency: none (wiring only).
// Backpressure: none here; the sequencer signals it through busy/drop.
interface jtopl_wr_seq_if;
    // CPU side
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] cpu_din;
    // Status
    logic       busy;
    logic       drop;
    // Register-file replay
    logic [7:0] din;
    logic       write;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult;
    logic       up_ksl_tl;
    logic       up_ar_dr;
    logic       up_sl_rr;
    logic       up_wav;
    logic       up_fnumlo;
    logic       up_fnumhi;
    logic       up_fbcon;
    // Global register fields
    logic       rhy_en;
    logic [4:0] rhy_kon;
    logic       am_dep;
    logic       vib_dep;
    logic       wave_mode;

    // Sequencer side
    modport slave (
        input  cs_n, wr_n, addr, cpu_din,
        output busy, drop, din, write, sel_group, sel_sub,
        output up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        output up_fnumlo, up_fnumhi, up_fbcon,
        output rhy_en, rhy_kon, am_dep, vib_dep, wave_mode
    );

    // Host / register-file side
    modport master (
        output cs_n, wr_n, addr, cpu_din,
        input  busy, drop, din, write, sel_group, sel_sub,
        input  up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        input  up_fnumlo, up_fnumhi, up_fbcon,
        input  rhy_en, rhy_kon, am_dep, vib_dep, wave_mode
    );
endinterface

// File: rtl/jtopl_wr_seq.sv
// OPL host write sequencer: queues CPU register writes and replays each for a full 18-slot rotation.
// Latency: data accept at T -> LOAD (write=1) at T+2 -> HOLD for 18 cen -> strobe falls the clk after.
// Backpressure: JTOPL_WRQ_EN gives a 2**QAW entry queue; otherwise a single holding register. Overflow -> drop.
module jtopl_wr_seq #(
    parameter int QAW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    jtopl_wr_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Decoded target of a register address; up is one-hot (bit0 mult .. bit7 fbcon) or zero.
    typedef struct packed {
        logic [7:0] up;
        logic [1:0] grp;
        logic [2:0] sub;
    } dec_t;

    localparam logic [4:0] HOLD_LAST = 5'd17;
    localparam logic [7:0] REG_RHY   = 8'hBD;
    localparam logic [7:0] REG_TEST  = 8'h01;

    // Map a register address onto its update strobe and group/subslot target.
    function automatic dec_t decode(input logic [7:0] r);
        dec_t d;
        d = '0;
        // Operator ranges: offset valid only for subslot 0..5 in groups 0..2
        if (r[2:0] < 3'd6 && r[4:3] != 2'b11) begin
            case (r[7:5])
                3'd1:    d.up = 8'h01;
                3'd2:    d.up = 8'h02;
                3'd3:    d.up = 8'h04;
                3'd4:    d.up = 8'h08;
                3'd7:    d.up = 8'h10;
                default: d.up = 8'h00;
            endcase
            if (d.up != 8'h00) begin
                d.grp = r[4:3];
                d.sub = r[2:0];
            end
        end
        // Channel ranges: channel 0..8 folds to group c/3, subslot c%3
        if (r[3:0] < 4'd9 && (r[7:4] == 4'hA || r[7:4] == 4'hB || r[7:4] == 4'hC)) begin
            case (r[7:4])
                4'hA:    d.up = 8'h20;
                4'hB:    d.up = 8'h40;
                default: d.up = 8'h80;
            endcase
            case (r[3:0])
                4'd0:    begin d.grp = 2'd0; d.sub = 3'd0; end
                4'd1:    begin d.grp = 2'd0; d.sub = 3'd1; end
                4'd2:    begin d.grp = 2'd0; d.sub = 3'd2; end
                4'd3:    begin d.grp = 2'd1; d.sub = 3'd0; end
                4'd4:    begin d.grp = 2'd1; d.sub = 3'd1; end
                4'd5:    begin d.grp = 2'd1; d.sub = 3'd2; end
                4'd6:    begin d.grp = 2'd2; d.sub = 3'd0; end
                4'd7:    begin d.grp = 2'd2; d.sub = 3'd1; end
                default: begin d.grp = 2'd2; d.sub = 3'd2; end
            endcase
        end
        return d;
    endfunction

    // Sequencer state
    state_t      state_q, state_d;
    logic [4:0]  hcnt_q, hcnt_d;
    logic [7:0]  ent_addr_q, ent_addr_d;
    logic [7:0]  selreg_q;
    logic        wr_n_q;

    // Registered outputs
    logic [7:0]  din_q, din_d;
    logic        write_q, write_d;
    logic [1:0]  grp_q, grp_d;
    logic [2:0]  sub_q, sub_d;
    logic [7:0]  up_q, up_d;
    logic        rhy_en_q, rhy_en_d;
    logic [4:0]  rhy_kon_q, rhy_kon_d;
    logic        am_dep_q, am_dep_d;
    logic        vib_dep_q, vib_dep_d;
    logic        wave_mode_q, wave_mode_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;

    // Bus accept: falling edge of wr_n qualified by chip select
    logic        accept;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic [15:0] head;
    logic        pend_d;
    dec_t        dec;

    assign accept = !bus.cs_n && !bus.wr_n && wr_n_q;
    assign push   = accept && bus.addr;

    // Write-strobe history and address-port latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q   <= 1'b1;
            selreg_q <= 8'h00;
        end else begin
            wr_n_q <= bus.wr_n;
            if (accept && !bus.addr) begin
                selreg_q <= bus.cpu_din;
            end
        end
    end

`ifdef JTOPL_WRQ_EN
    localparam int DEPTH = 1 << QAW;

    logic [15:0]  mem_q [DEPTH];
    logic [QAW:0] wptr_q, rptr_q, wptr_d, rptr_d;
    logic         q_empty, q_full;

    assign q_empty = (wptr_q == rptr_q);
    assign q_full  = (wptr_q[QAW] != rptr_q[QAW]) && (wptr_q[QAW-1:0] == rptr_q[QAW-1:0]);
    assign pop     = (state_q == ST_IDLE) && !q_empty;
    // A pop in the same clk frees a slot, so a push onto a full queue still lands
    assign push_ok = push && (!q_full || pop);
    assign head    = mem_q[rptr_q[QAW-1:0]];
    assign wptr_d  = wptr_q + {{QAW{1'b0}}, push_ok};
    assign rptr_d  = rptr_q + {{QAW{1'b0}}, pop};
    assign pend_d  = (wptr_d != rptr_d);

    // Queue pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Queue storage; only slots between the pointers are ever read, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[QAW-1:0]] <= {selreg_q, bus.cpu_din};
        end
    end
`else
    logic         hold_vld_q, hold_vld_d;
    logic [15:0]  hold_q;
    logic [QAW:0] unused_qaw;

    // Keeps the depth parameter referenced in the single-entry build
    assign unused_qaw = '0;
    assign pop        = (state_q == ST_IDLE) && hold_vld_q;
    assign push_ok    = push && !busy_q;
    assign head       = hold_q;
    assign hold_vld_d = push_ok || (hold_vld_q && !pop);
    assign pend_d     = hold_vld_d;

    // Single holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
            hold_q     <= 16'h0000;
        end else begin
            hold_vld_q <= hold_vld_d;
            if (push_ok) begin
                hold_q <= {selreg_q, bus.cpu_din};
            end
        end
    end
`endif

    assign dec = decode(head[15:8]);

    // Next state, replay outputs, global fields and status
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        ent_addr_d  = ent_addr_q;
        din_d       = din_q;
        write_d     = 1'b0;
        grp_d       = grp_q;
        sub_d       = sub_q;
        up_d        = up_q;
        rhy_en_d    = rhy_en_q;
        rhy_kon_d   = rhy_kon_q;
        am_dep_d    = am_dep_q;
        vib_dep_d   = vib_dep_q;
        wave_mode_d = wave_mode_q;
        drop_d      = push && !push_ok;

        case (state_q)
            ST_IDLE: begin
                up_d = 8'h00;
                if (pop) begin
                    ent_addr_d = head[15:8];
                    din_d      = head[7:0];
                    write_d    = 1'b1;
                    up_d       = dec.up;
                    if (dec.up != 8'h00) begin
                        grp_d = dec.grp;
                        sub_d = dec.sub;
                    end
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (up_q == 8'h00) begin
                    // Global or ignored address: one clk only, no rotation needed
                    if (ent_addr_q == REG_RHY) begin
                        am_dep_d  = din_q[7];
                        vib_dep_d = din_q[6];
                        rhy_en_d  = din_q[5];
                        rhy_kon_d = din_q[4:0];
                    end
                    if (ent_addr_q == REG_TEST) begin
                        wave_mode_d = din_q[5];
                    end
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d  = 5'd0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cen) begin
                    hcnt_d = hcnt_q + 5'd1;
                    if (hcnt_q == HOLD_LAST) begin
                        up_d    = 8'h00;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                up_d    = 8'h00;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || pend_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= 5'd0;
            ent_addr_q  <= 8'h00;
            din_q       <= 8'h00;
            write_q     <= 1'b0;
            grp_q       <= 2'd0;
            sub_q       <= 3'd0;
            up_q        <= 8'h00;
            rhy_en_q    <= 1'b0;
            rhy_kon_q   <= 5'd0;
            am_dep_q    <= 1'b0;
            vib_dep_q   <= 1'b0;
            wave_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            ent_addr_q  <= ent_addr_d;
            din_q       <= din_d;
            write_q     <= write_d;
            grp_q       <= grp_d;
            sub_q       <= sub_d;
            up_q        <= up_d;
            rhy_en_q    <= rhy_en_d;
            rhy_kon_q   <= rhy_kon_d;
            am_dep_q    <= am_dep_d;
            vib_dep_q   <= vib_dep_d;
            wave_mode_q <= wave_mode_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;
    assign bus.din       = din_q;
    assign bus.write     = write_q;
    assign bus.sel_group = grp_q;
    assign bus.sel_sub   = sub_q;
    assign bus.up_mult   = up_q[0];
    assign bus.up_ksl_tl = up_q[1];
    assign bus.up_ar_dr  = up_q[2];
    assign bus.up_sl_rr  = up_q[3];
    assign bus.up_wav    = up_q[4];
    assign bus.up_fnumlo = up_q[5];
    assign bus.up_fnumhi = up_q[6];
    assign bus.up_fbcon  = up_q[7];
    assign bus.rhy_en    = rhy_en_q;
    assign bus.rhy_kon   = rhy_kon_q;
    assign bus.am_dep    = am_dep_q;
    assign bus.vib_dep   = vib_dep_q;
    assign bus.wave_mode = wave_mode_q;

endmodule

// File: tb/tb_jtopl_wr_seq.sv
// Self-checking bench for jtopl_wr_seq: directed CPU writes, scoreboard of expected replays.
// A monitor pops the expected replay on every write pulse and times the strobe in cen ticks.
// Works with or without JTOPL_WRQ_EN defined.
module tb_jtopl_wr_seq;

    typedef struct packed {
        logic [7:0] up;
        logic [1:0] grp;
        logic [2:0] sub;
        logic [7:0] din;
        logic       chk_sel;
    } exp_t;

    logic clk;
    logic rst_n;
    logic cen;
    bit   cen_en;

    int   n_tests;
    int   n_fail;
    int   drops_seen;
    int   writes_seen;

    exp_t exp_q[$];

    jtopl_wr_seq_if bus();

    jtopl_wr_seq #(.QAW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    logic [7:0] up_vec;
    assign up_vec = {bus.up_fbcon, bus.up_fnumhi, bus.up_fnumlo, bus.up_wav,
                     bus.up_sl_rr, bus.up_ar_dr, bus.up_ksl_tl, bus.up_mult};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen ticks every other clk while enabled
    initial begin
        cen    = 1'b0;
        cen_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cen = cen_en ? ~cen : 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_rep(input logic [7:0] up, input logic [1:0] grp, input logic [2:0] sub,
                              input logic [7:0] din, input logic chk_sel);
        exp_t e;
        e.up      = up;
        e.grp     = grp;
        e.sub     = sub;
        e.din     = din;
        e.chk_sel = chk_sel;
        exp_q.push_back(e);
    endtask

    // One CPU write cycle: strobe low for one clk, then high for at least one clk
    task automatic cpu_wr(input logic a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.cs_n    = 1'b0;
        bus.wr_n    = 1'b0;
        bus.addr    = a;
        bus.cpu_din = d;
        @(posedge clk);
        #1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 800) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, bus.busy, 1'b0);
    endtask

    // Monitor: every write pulse must match the next expected replay
    initial begin
        exp_t cur;
        bit   in_str;
        int   cen_cnt;
        cur     = '0;
        in_str  = 1'b0;
        cen_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_str = 1'b0;
                continue;
            end
            if (bus.drop) drops_seen++;
            if (bus.write) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL write_unexpected: got write with din=0x%0h, required none", bus.din);
                end else begin
                    cur = exp_q.pop_front();
                    chk("load_strobe", {24'h0, up_vec}, {24'h0, cur.up});
                    chk("load_din", {24'h0, bus.din}, {24'h0, cur.din});
                    if (cur.chk_sel) begin
                        chk("load_group", {30'h0, bus.sel_group}, {30'h0, cur.grp});
                        chk("load_sub", {29'h0, bus.sel_sub}, {29'h0, cur.sub});
                    end
                    in_str  = (cur.up != 8'h00);
                    cen_cnt = 0;
                end
            end else if (in_str) begin
                if (up_vec == cur.up) begin
                    if (cen) cen_cnt++;
                end else begin
                    chk("strobe_fall", {24'h0, up_vec}, 32'h0);
                    chk("hold_cens", cen_cnt, 18);
                    in_str = 1'b0;
                end
            end
        end
    end

    initial begin
        int d0;
        int w0;
        n_tests     = 0;
        n_fail      = 0;
        drops_seen  = 0;
        writes_seen = 0;
        bus.cs_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.addr    = 1'b0;
        bus.cpu_din = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_drop", bus.drop, 1'b0);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_din", {24'h0, bus.din}, 32'h0);
        chk("rst_strobes", {24'h0, up_vec}, 32'h0);
        chk("rst_sel", {27'h0, bus.sel_group, bus.sel_sub}, 32'h0);
        chk("rst_globals", {23'h0, bus.am_dep, bus.vib_dep, bus.rhy_en, bus.rhy_kon, bus.wave_mode}, 32'h0);
        rst_n = 1'b1;

        // Operator write: 0x23 -> mult, group 0, sub 3
        expect_rep(8'h01, 2'd0, 3'd3, 8'h41, 1'b1);
        cpu_wr(1'b0, 8'h23);
        chk("addr_no_busy", bus.busy, 1'b0);
        cpu_wr(1'b1, 8'h41);
        chk("busy_rise", bus.busy, 1'b1);
        wait_idle("mult_idle");
        chk("mult_after", {24'h0, up_vec}, 32'h0);

        // Channel write: 0xB7 -> fnumhi, channel 7 = group 2, sub 1
        expect_rep(8'h40, 2'd2, 3'd1, 8'h2A, 1'b1);
        cpu_wr(1'b0, 8'hB7);
        cpu_wr(1'b1, 8'h2A);
        wait_idle("fnumhi_idle");

        // Ignored addresses: one LOAD clk, no strobe
        expect_rep(8'h00, 2'd0, 3'd0, 8'h55, 1'b0);
        cpu_wr(1'b0, 8'hA9);
        cpu_wr(1'b1, 8'h55);
        @(posedge clk);
        #1;
        chk("ign_busy_load", bus.busy, 1'b1);
        @(posedge clk);
        #1;
        chk("ign_busy_fall", bus.busy, 1'b0);
        expect_rep(8'h00, 2'd0, 3'd0, 8'h66, 1'b0);
        cpu_wr(1'b0, 8'h26);
        cpu_wr(1'b1, 8'h66);
        wait_idle("ign2_idle");

        // Global registers
        expect_rep(8'h00, 2'd0, 3'd0, 8'hE5, 1'b0);
        cpu_wr(1'b0, 8'hBD);
        cpu_wr(1'b1, 8'hE5);
        wait_idle("bd_idle");
        chk("am_dep", bus.am_dep, 1'b1);
        chk("vib_dep", bus.vib_dep, 1'b1);
        chk("rhy_en", bus.rhy_en, 1'b1);
        chk("rhy_kon", {27'h0, bus.rhy_kon}, 32'h05);
        expect_rep(8'h00, 2'd0, 3'd0, 8'h20, 1'b0);
        cpu_wr(1'b0, 8'h01);
        cpu_wr(1'b1, 8'h20);
        wait_idle("r01_idle");
        chk("wave_mode", bus.wave_mode, 1'b1);
        chk("rhy_kon_kept", {27'h0, bus.rhy_kon}, 32'h05);

        // Overflow: back-to-back data writes while a replay holds
        d0 = drops_seen;
        cpu_wr(1'b0, 8'h40);
`ifdef JTOPL_WRQ_EN
        for (int i = 0; i < 5; i++) begin
            expect_rep(8'h02, 2'd0, 3'd0, 8'h11 + 8'(i), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            cpu_wr(1'b1, 8'h11 + 8'(i));
        end
`else
        expect_rep(8'h02, 2'd0, 3'd0, 8'h11, 1'b1);
        cpu_wr(1'b1, 8'h11);
        cpu_wr(1'b1, 8'h12);
`endif
        wait_idle("ovf_idle");
        chk("ovf_drops", drops_seen - d0, 1);

        // Reset in the middle of HOLD
        expect_rep(8'h04, 2'd0, 3'd0, 8'h33, 1'b1);
        cpu_wr(1'b0, 8'h60);
        cpu_wr(1'b1, 8'h33);
`ifdef JTOPL_WRQ_EN
        cpu_wr(1'b1, 8'h34);
        cpu_wr(1'b1, 8'h35);
`endif
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_strobe", {24'h0, up_vec}, 32'h04);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobe", {24'h0, up_vec}, 32'h0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_am", bus.am_dep, 1'b0);
        // selreg cleared by reset: a bare data write targets 0x00, which is ignored
        expect_rep(8'h00, 2'd0, 3'd0, 8'h5A, 1'b0);
        cpu_wr(1'b1, 8'h5A);
        wait_idle("selreg_rst_idle");

        // Strobe held low for 10 clk: exactly one push
        d0 = drops_seen;
        w0 = writes_seen;
        expect_rep(8'h01, 2'd0, 3'd1, 8'h77, 1'b1);
        cpu_wr(1'b0, 8'h21);
        @(posedge clk);
        #1;
        bus.cs_n    = 1'b0;
        bus.wr_n    = 1'b0;
        bus.addr    = 1'b1;
        bus.cpu_din = 8'h77;
        repeat (10) @(posedge clk);
        #1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        wait_idle("held_idle");
        chk("held_writes", writes_seen - w0, 1);
        chk("held_drops", drops_seen - d0, 0);

        // cen stuck low: HOLD never finishes; address writes still accepted
        cen_en = 1'b0;
        expect_rep(8'h08, 2'd0, 3'd0, 8'h01, 1'b1);
        cpu_wr(1'b0, 8'h80);
        cpu_wr(1'b1, 8'h01);
        repeat (60) @(posedge clk);
        #1;
        chk("stuck_busy", bus.busy, 1'b1);
        chk("stuck_strobe", {24'h0, up_vec}, 32'h08);
        cpu_wr(1'b0, 8'hBD);
        chk("addr_while_busy", bus.busy, 1'b1);
        cen_en = 1'b1;
        wait_idle("stuck_idle");
        expect_rep(8'h00, 2'd0, 3'd0, 8'h00, 1'b0);
        cpu_wr(1'b1, 8'h00);
        wait_idle("bd_clr_idle");
        chk("bd_clr_am", bus.am_dep, 1'b0);
        chk("bd_clr_kon", {27'h0, bus.rhy_kon}, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
